// File: rtl/ak4619_pkg.sv
// +----------------------------------------------------------------------------
// | ak4619_pkg : shared frame geometry and index types for the AK4619 TDM link
// | Revision   : 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package ak4619_pkg;

  localparam int FRAME_CYCLES = 256;
  localparam int N_SLOTS      = 4;
  localparam int SLOT_BITS    = 32;
  localparam int CNT_W        = $clog2(FRAME_CYCLES);
  localparam int BIT_W        = $clog2(SLOT_BITS);

  typedef logic [1:0]       slot_t;
  typedef logic [BIT_W-1:0] slot_bit_t;

endpackage

`default_nettype wire

// File: rtl/ak4619_tdm_if.sv
// +----------------------------------------------------------------------------
// | ak4619_tdm_if : codec pins plus parallel ADC/DAC sample bus
// | Revision      : 1.0
// +----------------------------------------------------------------------------
`default_nettype none

interface ak4619_tdm_if #(
  parameter int W = 16
);

  logic                sdin1;
  logic                sdout1;
  logic                bick;
  logic                lrck;
  logic                clk_fs;
  logic signed [W-1:0] dac0, dac1, dac2, dac3;
  logic signed [W-1:0] adc0, adc1, adc2, adc3;

  modport master (
    input  sdin1, dac0, dac1, dac2, dac3,
    output sdout1, bick, lrck, clk_fs, adc0, adc1, adc2, adc3
  );

  modport slave (
    output sdin1, dac0, dac1, dac2, dac3,
    input  sdout1, bick, lrck, clk_fs, adc0, adc1, adc2, adc3
  );

endinterface

`default_nettype wire

// File: rtl/ak4619_tdm_frame_timer.sv
// +----------------------------------------------------------------------------
// | tdm_frame_timer : free-running 256-cycle frame counter and its decodes
// | Revision        : 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tdm_frame_timer
  import ak4619_pkg::*;
(
  input  logic      clk_256fs,
  input  logic      rst,
  output logic      bick,
  output logic      lrck,
  output logic      clk_fs,
  output slot_t     slot,
  output slot_bit_t bit_idx,
  output slot_t     nxt_slot,
  output slot_bit_t nxt_bit,
  output logic      frame_end,
  output logic      fall_stb
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk_256fs) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bick      = cnt_q[0];
  assign lrck      = ~cnt_q[7];
  assign clk_fs    = ~cnt_q[7];
  assign slot      = cnt_q[7:6];
  assign bit_idx   = cnt_q[5:1];
  // Decodes of the count about to be entered, for the registered serialiser.
  assign nxt_slot  = cnt_d[7:6];
  assign nxt_bit   = cnt_d[5:1];
  assign frame_end = &cnt_q;
  assign fall_stb  = cnt_q[0];

endmodule

`default_nettype wire

// File: rtl/ak4619_tdm.sv
// +----------------------------------------------------------------------------
// | ak4619_tdm : TDM128 codec link, 4 ADC slots in, 4 DAC slots out.
// | Option     : AK4619_TDM_LOOPBACK_EN feeds sdout1 back into the deserialiser.
// | Revision   : 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module ak4619_tdm
  import ak4619_pkg::*;
#(
  parameter int W = 16
) (
  input  logic          clk_256fs,
  input  logic          rst,
  ak4619_tdm_if.master  bus
);

  logic      bick, lrck, clk_fs, frame_end, fall_stb;
  slot_t     slot, nxt_slot;
  slot_bit_t bit_idx, nxt_bit;

  tdm_frame_timer u_timer (
    .clk_256fs (clk_256fs),
    .rst       (rst),
    .bick      (bick),
    .lrck      (lrck),
    .clk_fs    (clk_fs),
    .slot      (slot),
    .bit_idx   (bit_idx),
    .nxt_slot  (nxt_slot),
    .nxt_bit   (nxt_bit),
    .frame_end (frame_end),
    .fall_stb  (fall_stb)
  );

  logic signed [W-1:0] dac_in  [N_SLOTS];
  logic signed [W-1:0] shadow_q[N_SLOTS], shadow_d[N_SLOTS];
  logic signed [W-1:0] cap_q   [N_SLOTS], cap_d   [N_SLOTS];
  logic signed [W-1:0] adc_q   [N_SLOTS], adc_d   [N_SLOTS];
  logic [W-1:0]        sr_q, sr_d, sr_shift, tx_shift;
  logic                sdout1_q, sdout1_d;
  logic                rx_bit, in_sample, last_bit;

  assign dac_in[0] = bus.dac0;
  assign dac_in[1] = bus.dac1;
  assign dac_in[2] = bus.dac2;
  assign dac_in[3] = bus.dac3;

`ifdef AK4619_TDM_LOOPBACK_EN
  assign rx_bit = sdout1_q;
`else
  assign rx_bit = bus.sdin1;
`endif

  assign in_sample = {1'b0, bit_idx} <  6'(W);
  assign last_bit  = {1'b0, bit_idx} == 6'(W - 1);
  assign sr_shift  = {sr_q[W-2:0], rx_bit};

  always_comb begin
    shadow_d = shadow_q;
    cap_d    = cap_q;
    adc_d    = adc_q;
    sr_d     = sr_q;
    sdout1_d = sdout1_q;

    if (frame_end) shadow_d = dac_in;

    // Shifting past the sample width yields zero, which is the slot padding.
    tx_shift = shadow_d[nxt_slot] << nxt_bit;
    if (fall_stb) sdout1_d = tx_shift[W-1];

    if (fall_stb && in_sample) begin
      sr_d = sr_shift;
      if (last_bit) cap_d[slot] = sr_shift;
    end

    // Use cap_d so a W=32 slot 3, which completes on this same edge, is kept.
    if (frame_end) adc_d = cap_d;
  end

  always_ff @(posedge clk_256fs) begin
    if (rst) begin
      shadow_q <= '{default: '0};
      cap_q    <= '{default: '0};
      adc_q    <= '{default: '0};
      sr_q     <= '0;
      sdout1_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      cap_q    <= cap_d;
      adc_q    <= adc_d;
      sr_q     <= sr_d;
      sdout1_q <= sdout1_d;
    end
  end

  assign bus.sdout1 = sdout1_q;
  assign bus.bick   = bick;
  assign bus.lrck   = lrck;
  assign bus.clk_fs = clk_fs;
  assign bus.adc0   = adc_q[0];
  assign bus.adc1   = adc_q[1];
  assign bus.adc2   = adc_q[2];
  assign bus.adc3   = adc_q[3];

endmodule

`default_nettype wire
